// File: rtl/crc_pkg.sv
// Shared CRC-8 constants, FSM state type and the per-frame status record.
package crc_pkg;

    localparam int WIDTH   = 8;
    localparam logic [WIDTH-1:0] POLY = 8'h07;
    localparam int MAX_LEN = 64;
    localparam int CNT_W   = $clog2(MAX_LEN + 2);

    typedef enum logic [1:0] {
        IDLE,
        RECV,
        REPORT
    } state_t;

    typedef struct packed {
        logic             crc_ok;
        logic             len_err;
        logic             parity_err;
        logic [CNT_W-1:0] byte_cnt;
        logic [WIDTH-1:0] crc_value;
    } frame_status_t;

endpackage

// File: rtl/crc8_byte_step.sv
// One byte of MSB-first CRC-8 (init/no reflection handled by the caller).
module crc8_byte_step
    import crc_pkg::*;
(
    input  logic [WIDTH-1:0] crc_in,
    input  logic [7:0]       data,
    output logic [WIDTH-1:0] crc_out
);

    always_comb begin
        crc_out = crc_in ^ data;
        for (int unsigned i = 0; i < 8; i++) begin
            crc_out = crc_out[WIDTH-1] ? ((crc_out << 1) ^ POLY) : (crc_out << 1);
        end
    end

endmodule

// File: rtl/crc_frame_checker.sv
// Receive-side CRC-8 frame checker with length and per-byte parity checks.
// Optional per-byte even-parity checking is enabled by defining PARITY_CHECK_EN.
module crc_frame_checker
    import crc_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_data,
    input  logic             in_last,
    input  logic             in_parity,
    output logic             status_valid,
    input  logic             status_ready,
    output logic             crc_ok,
    output logic             len_err,
    output logic             parity_err,
    output logic [CNT_W-1:0] byte_cnt,
    output logic [WIDTH-1:0] crc_value
);

    localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(MAX_LEN + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(2);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] crc_q, crc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             par_q, par_d;
    frame_status_t    status_q, status_d;

    logic             accept;
    logic             byte_bad;
    logic [WIDTH-1:0] crc_base;
    logic [WIDTH-1:0] crc_step;
    logic [CNT_W-1:0] cnt_next;
    logic             par_next;
    logic             len_bad;

`ifdef PARITY_CHECK_EN
    assign byte_bad = ((^in_data) != in_parity);
`else
    logic unused_parity;
    assign unused_parity = in_parity;
    assign byte_bad      = 1'b0;
`endif

    assign in_ready = reset && (state_q != REPORT);
    assign accept   = in_valid && in_ready;

    // A frame always starts from CRC 0, so IDLE bypasses the running register.
    assign crc_base = (state_q == IDLE) ? '0 : crc_q;

    crc8_byte_step u_step (
        .crc_in  (crc_base),
        .data    (in_data),
        .crc_out (crc_step)
    );

    always_comb begin
        if (state_q == IDLE) begin
            cnt_next = CNT_W'(1);
            par_next = byte_bad;
        end else begin
            cnt_next = (cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1);
            par_next = par_q | byte_bad;
        end
        len_bad = (cnt_next < CNT_MIN) || (cnt_next > CNT_MAX);
    end

    always_comb begin
        state_d  = state_q;
        crc_d    = crc_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        status_d = status_q;
        unique case (state_q)
            IDLE, RECV: begin
                if (accept) begin
                    crc_d   = crc_step;
                    cnt_d   = cnt_next;
                    par_d   = par_next;
                    state_d = RECV;
                    if (in_last) begin
                        state_d             = REPORT;
                        status_d.crc_value  = crc_step;
                        status_d.byte_cnt   = cnt_next;
                        status_d.len_err    = len_bad;
                        status_d.parity_err = par_next;
                        status_d.crc_ok     = (crc_step == '0) && !len_bad;
                    end
                end
            end
            REPORT: begin
                if (status_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            crc_q    <= '0;
            cnt_q    <= '0;
            par_q    <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            crc_q    <= crc_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            status_q <= status_d;
        end
    end

    assign status_valid = (state_q == REPORT);
    assign crc_ok       = status_q.crc_ok;
    assign len_err      = status_q.len_err;
    assign parity_err   = status_q.parity_err;
    assign byte_cnt     = status_q.byte_cnt;
    assign crc_value    = status_q.crc_value;

endmodule

// File: doc/crc_frame_checker.md
Name: crc_frame_checker

Overview:
Receive-side stage that consumes byte frames protected by the CRC-8 (poly 0x07) our generator produces and checks them. Bytes arrive on a valid/ready stream; the last byte of each frame is the CRC. A running CRC is taken over the whole frame, with length and per-byte even-parity checks alongside. One status record is emitted per frame and is held until the consumer accepts it.

Parameters:
WIDTH, 8, CRC width in bits; fixed to 8 for this block.
POLY, 8'h07, CRC polynomial. MSB-first, init 0x00, no reflection, no final XOR.
MAX_LEN, 64, maximum legal frame length in bytes, including the CRC byte.
CNT_W, $clog2(MAX_LEN+2), width of the byte counter.

Ports:
clk  input  1  clock; all logic on rising edge
reset  input  1  synchronous, active-low reset (asserted when 0)
in_valid  input  1  in_data, in_last and in_parity are valid
in_ready  output  1  block accepts a byte this cycle
in_data  input  8  frame byte
in_last  input  1  marks the final byte (the CRC byte)
in_parity  input  1  even-parity bit sent with in_data
status_valid  output  1  frame status available
status_ready  input  1  consumer accepts the status
crc_ok  output  1  residual CRC == 0 and no length error
len_err  output  1  frame shorter than 2 bytes or longer than MAX_LEN
parity_err  output  1  at least one byte failed the parity check
byte_cnt  output  CNT_W  bytes received; saturates at MAX_LEN+1
crc_value  output  8  residual CRC after the last byte

Behaviour:
- Reset (reset==0 at a clock edge):
  - state <= IDLE.
  - crc_reg, counters and all status outputs <= 0.
  - in_ready is 0 while reset is asserted.
  - Reset mid-frame or mid-REPORT discards everything; no status is emitted for the aborted frame.
- A byte is accepted when in_valid && in_ready. in_ready = (state != REPORT) && reset deasserted.
- FSM states: IDLE, RECV, REPORT.
  - IDLE: on an accepted byte, start the frame.
    - crc_reg <= step(0x00, in_data); byte_cnt <= 1.
    - If in_last is also set: go to REPORT with len_err=1 (1-byte frame). Otherwise go to RECV.
  - RECV: on each accepted byte:
    - crc_reg <= step(crc_reg, in_data).
    - byte_cnt <= min(byte_cnt+1, MAX_LEN+1).
    - On in_last: go to REPORT.
    - Bytes beyond MAX_LEN are still consumed and CRC'd until in_last; len_err is set.
  - REPORT: status_valid=1 and all status outputs are held stable.
    - When status_ready is high, go to IDLE and clear status_valid.
    - in_ready=0 throughout REPORT, so there is no overlap between frames.
- step(c,d): x = c ^ d, then 8 iterations of x = x[7] ? (x<<1)^POLY : x<<1.
- crc_ok = (crc_value == 0) && !len_err. crc_value is the residual crc_reg.
- Latency: status_valid rises on the clock edge that accepts the in_last byte, so it is visible the following cycle.
- A status can be accepted in its first cycle; the next frame's first byte can then be accepted one cycle later, in IDLE.
- in_valid while in REPORT is ignored and the byte is not consumed. The upstream stage must hold its data.
- in_valid deasserted mid-frame: the block waits in RECV indefinitely; there is no timeout.

Optional Feature:
PARITY_CHECK_EN
- Defined: each accepted byte is checked with (^in_data) != in_parity. Any mismatch sets a sticky per-frame flag, which is reported as parity_err. parity_err does not affect crc_ok.
- Undefined: in_parity is ignored and parity_err is tied to 0. The port remains so the interface is identical.

Decomposition:
- Package crc_pkg: WIDTH, POLY, the state enum type (IDLE/RECV/REPORT), and a frame status struct {crc_ok, len_err, parity_err, byte_cnt, crc_value}.
- One sub-module, crc8_byte_step: combinational, taking crc_in[7:0] and data[7:0] and returning crc_out[7:0]. It is reusable by the generator side.
- The FSM, counters and status register live in crc_frame_checker.

Test Plan:
1. Frame 31 32 33 34 35 36 37 38 39 F4 ("123456789" + CRC) -> status_valid, crc_ok=1, crc_value=0x00, byte_cnt=10, len_err=0.
2. Same frame with last byte F5 -> crc_ok=0, crc_value=0x07, byte_cnt=10.
3. Frame 01 07, second byte sent with wrong in_parity:
   - With PARITY_CHECK_EN -> crc_ok=1, parity_err=1.
   - Without it -> parity_err=0.
4. Single byte 0xAA with in_last -> len_err=1, crc_ok=0, byte_cnt=1, status after 1 cycle.
5. MAX_LEN=64, 70-byte frame -> in_ready stays high until last; len_err=1, byte_cnt=65, crc_ok=0.
6. Backpressure and reset:
   - Hold status_ready=0 for 5 cycles after frame 1 -> status stable and in_ready=0; in_valid bytes are not consumed.
   - Release -> next frame is accepted.
   - Drive reset=0 after byte 3 of a frame -> no status emitted, IDLE, outputs 0.
